// File: rtl/adder.sv
// adder: registered 8-bit two's-complement adder with a 9-bit sign-extended sum and carry/overflow/zero/sign status.
module adder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       flag,
  output logic [8:0] z,
  output logic       valid,
  output logic       cout,
  output logic       ovf,
  output logic       zero,
  output logic       neg
);
  logic [8:0] xe, ye, sum;
  logic [8:0] c;
  logic [8:0] z_d, z_q;
  logic       valid_d, valid_q, cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q, neg_d, neg_q;
  assign xe   = {x[7], x};
  assign ye   = {y[7], y};
  assign c[0] = 1'b0;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]   = xe[i] ^ ye[i] ^ c[i];
    assign c[i + 1] = (xe[i] & ye[i]) | (c[i] & (xe[i] ^ ye[i]));
  end
  // The top cell's carry-out has no meaning for a sign-extended sum, so only its sum bit is built.
  assign sum[8] = xe[8] ^ ye[8] ^ c[8];
  always_comb begin
    z_d     = flag ? sum : z_q;
    valid_d = flag;
    cout_d  = flag ? c[8] : cout_q;
    ovf_d   = flag ? sum[8] ^ sum[7] : ovf_q;
    zero_d  = flag ? (sum == 9'd0) : zero_q;
    neg_d   = flag ? sum[8] : neg_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z_q     <= 9'd0;
      valid_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
    end else begin
      z_q     <= z_d;
      valid_q <= valid_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end
  assign z     = z_q;
  assign valid = valid_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;
  assign zero  = zero_q;
  assign neg   = neg_q;
endmodule

// File: tb/tb_adder.sv
// tb_adder: scoreboard bench for adder; stimulus pushes hand-computed results, a negedge monitor pops them on valid.
module tb_adder;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x, y;
  logic       flag;
  logic [8:0] z;
  logic       valid, cout, ovf, zero, neg;

  typedef struct {
    logic [8:0] z;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic       neg;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   pushed = 0;
  int   seen = 0;

  adder dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .flag(flag),
    .z(z), .valid(valid), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [8:0] ez, input logic ec, input logic eo);
    exp_t e;
    e.z    = ez;
    e.cout = ec;
    e.ovf  = eo;
    e.zero = (ez == 9'd0);
    e.neg  = ez[8];
    sb.push_back(e);
    pushed++;
  endtask

  task automatic add(input logic [7:0] a, input logic [7:0] b, input logic [8:0] ez, input logic ec, input logic eo);
    @(negedge clk);
    x = a;
    y = b;
    flag = 1'b1;
    push(ez, ec, eo);
    @(negedge clk);
    flag = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_z"}, 32'(z), 32'h000);
    chk({tag, "_valid"}, 32'(valid), 32'h0);
    chk({tag, "_cout"}, 32'(cout), 32'h0);
    chk({tag, "_ovf"}, 32'(ovf), 32'h0);
    chk({tag, "_zero"}, 32'(zero), 32'h1);
    chk({tag, "_neg"}, 32'(neg), 32'h0);
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      seen++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got z=%0h with no expected result queued", z);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("z", 32'(z), 32'(e.z));
        chk("cout", 32'(cout), 32'(e.cout));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("zero", 32'(zero), 32'(e.zero));
        chk("neg", 32'(neg), 32'(e.neg));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b0;
    flag = 1'b0;
    x    = 8'h00;
    y    = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b1;
    add(8'h08, 8'hFB, 9'h003, 1'b1, 1'b0);
    add(8'hFF, 8'hFF, 9'h1FE, 1'b1, 1'b0);
    add(8'h80, 8'hFF, 9'h17F, 1'b1, 1'b1);
    add(8'h7F, 8'h01, 9'h080, 1'b0, 1'b1);
    add(8'hC0, 8'h20, 9'h1E0, 1'b0, 1'b0);
    x = 8'h33;
    y = 8'h44;
    @(negedge clk);
    chk("hold_z", 32'(z), 32'h1E0);
    chk("hold_valid", 32'(valid), 32'h0);
    chk("hold_neg", 32'(neg), 32'h1);
    // Back-to-back strobes: valid must stay high and both results appear in order.
    @(negedge clk);
    x = 8'h01;
    y = 8'h02;
    flag = 1'b1;
    push(9'h003, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_valid", 32'(valid), 32'h1);
    x = 8'hFF;
    y = 8'h01;
    push(9'h000, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b_valid2", 32'(valid), 32'h1);
    flag = 1'b0;
    @(negedge clk);
    chk("b2b_valid_drop", 32'(valid), 32'h0);
    add(8'hC0, 8'h20, 9'h1E0, 1'b0, 1'b0);
    @(negedge clk);
    x = 8'h11;
    y = 8'h22;
    flag = 1'b1;
    #1 rst = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge clk);
    chk_reset("rst_held");
    rst  = 1'b1;
    x    = 8'h05;
    y    = 8'hFB;
    push(9'h000, 1'b1, 1'b0);
    @(negedge clk);
    flag = 1'b0;
    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    chk("valid_count", 32'(seen), 32'(pushed));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
